apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- APB requester that drives the team's APB slave.
- Accepts single read/write commands on a valid/ready command port and runs the APB IDLE→SETUP→ACCESS sequence.
- Waits for pready, then returns read data and error status on a one-cycle response strobe.
- Sits between the system command source (CPU/testbench sequencer) and the APB slave bus.

Parameters:
- ADDR_W, 5, width of paddr / cmd_addr (32-word slave space).
- DATA_W, 32, width of pwdata/prdata; pstrobe width is DATA_W/8.
- TIMEOUT_CYCLES, 16, max ACCESS wait cycles before abort (used only with APB_MASTER_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  bridge can accept a command
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  word address
- cmd_wdata  in  DATA_W  write data
- cmd_strobe  in  DATA_W/8  byte enables (writes)
- cmd_prot  in  3  protection attributes
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_W  read data (writes: 0)
- rsp_err  out  1  slave error or timeout
- rsp_timeout  out  1  completion was a timeout abort
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- pstrobe  out  DATA_W/8  APB byte strobes
- pprot  out  3  APB protection
- pready  in  1  slave ready
- pslverr  in  1  slave error
- prdata  in  DATA_W  slave read data

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset: state=IDLE; psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout = 0; paddr, pwdata, pstrobe, pprot, rsp_rdata = 0. Reset asserted mid-transfer aborts immediately; the next cycle shows psel=0 and no rsp_valid.
- States: IDLE, SETUP, ACCESS.
- cmd_ready = (state==IDLE). A command is accepted when cmd_valid && cmd_ready.
- On accept, all cmd_* fields are registered into paddr/pwrite/pwdata/pstrobe/pprot; next state is SETUP. Fields stay stable until the transfer completes.
- SETUP (exactly 1 cycle): psel=1, penable=0. Next state is ACCESS unconditionally.
- ACCESS: psel=1, penable=1. pready is sampled each cycle.
  - pready=0: stay in ACCESS (wait state).
  - pready=1: transfer completes. Next state IDLE; psel=0, penable=0.
  - In the same completion edge, register rsp_rdata = pwrite ? 0 : prdata and rsp_err = pslverr. rsp_valid=1 for exactly one cycle, coinciding with the first IDLE cycle.
- pslverr and prdata are ignored unless pready=1 in ACCESS.
- rsp_rdata/rsp_err hold their values until the next completion. rsp_valid is a pulse with no backpressure.
- Minimum latency: accept at cycle N, SETUP at N+1, ACCESS at N+2, with pready=1 at N+2 → rsp_valid at N+3. Each pready=0 cycle adds 1.
- Back-to-back: cmd_ready is high in the rsp_valid cycle, so a new command can be accepted there. Peak rate is one transfer per 3 cycles.
- cmd_valid while busy is ignored (cmd_ready=0); the source must hold it.
- Address has no wrap logic: paddr is cmd_addr truncated to ADDR_W.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entering ACCESS and increments each ACCESS cycle with pready=0.
  - When it reaches TIMEOUT_CYCLES, the bridge forces IDLE (psel=0) and pulses rsp_valid with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - pready=1 in the same cycle as the counter reaching its limit counts as a normal completion (pready wins).
- Undefined: no counter; the bridge waits indefinitely; rsp_timeout is tied 0.

Test Plan:
- Write addr=5, wdata=0xDEADBEEF, strobe=4'hF, prot=0, pready high in ACCESS → SETUP then ACCESS with correct bus fields; rsp_valid 3 cycles after accept; rsp_err=0, rsp_rdata=0.
- Read addr=5 after the write, slave returns 0xDEADBEEF → rsp_rdata=0xDEADBEEF, rsp_err=0; psel deasserted in the rsp_valid cycle.
- Slave holds pready=0 for 4 cycles then asserts it with pslverr=1 → bus fields stable throughout; rsp_valid at accept+7; rsp_err=1.
- Two commands presented back-to-back with cmd_valid held → second accepted in the first's rsp_valid cycle; responses 3 cycles apart.
- reset=1 asserted while in ACCESS → next cycle psel=0, penable=0, cmd_ready=1, no rsp_valid.
- With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, pready held 0 → rsp_valid with rsp_err=1, rsp_timeout=1 after 16 ACCESS wait cycles; psel dropped.

Source files
------------

// File: rtl/apb_master_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_bridge_if
// Brief    : Command/response port and APB bus bundle for apb_master_bridge.
// Revision : 1.0 - initial release
// ============================================================================
interface apb_master_bridge_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_W-1:0]     cmd_addr;
  logic [DATA_W-1:0]     cmd_wdata;
  logic [DATA_W/8-1:0]   cmd_strobe;
  logic [2:0]            cmd_prot;

  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_W-1:0]     paddr;
  logic [DATA_W-1:0]     pwdata;
  logic [DATA_W/8-1:0]   pstrobe;
  logic [2:0]            pprot;
  logic                  pready;
  logic                  pslverr;
  logic [DATA_W-1:0]     prdata;

  // Bridge side: consumes commands, drives the APB request signals.
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strobe, cmd_prot,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output psel, penable, pwrite, paddr, pwdata, pstrobe, pprot,
    input  pready, pslverr, prdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strobe, cmd_prot,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  psel, penable, pwrite, paddr, pwdata, pstrobe, pprot,
    output pready, pslverr, prdata
  );
endinterface
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_bridge
// Brief    : Single-command APB requester (IDLE/SETUP/ACCESS) with one-cycle
//            response strobe. Define APB_MASTER_TIMEOUT_EN to add the ACCESS
//            wait-state timeout abort.
// Revision : 1.0 - initial release
// ============================================================================
module apb_master_bridge #(
  parameter int ADDR_W         = 5,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  apb_master_bridge_if.master bus
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t              state_q;
  logic                psel_q;
  logic                penable_q;
  logic                pwrite_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic [STRB_W-1:0]   pstrobe_q;
  logic [2:0]          pprot_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_err_q;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0]    wait_cnt_q;
  logic                rsp_timeout_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrobe_q   <= '0;
      pprot_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt_q    <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            pwrite_q  <= bus.cmd_write;
            paddr_q   <= bus.cmd_addr;
            pwdata_q  <= bus.cmd_wdata;
            pstrobe_q <= bus.cmd_strobe;
            pprot_q   <= bus.cmd_prot;
            psel_q    <= 1'b1;
            state_q   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ST_ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
        end
        ST_ACCESS: begin
          // pready is checked first so a ready slave wins over the timeout.
          if (bus.pready) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= pwrite_q ? '0 : bus.prdata;
            rsp_err_q   <= bus.pslverr;
            state_q     <= ST_IDLE;
`ifdef APB_MASTER_TIMEOUT_EN
            rsp_timeout_q <= 1'b0;
          end else if (wait_cnt_q == WAIT_LIMIT) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            state_q       <= ST_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
`endif
          end
        end
        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.pstrobe   = pstrobe_q;
  assign bus.pprot     = pprot_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

`ifdef APB_MASTER_TIMEOUT_EN
  assign bus.rsp_timeout = rsp_timeout_q;
`else
  assign bus.rsp_timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master_bridge
// Brief    : Randomized self-checking bench for apb_master_bridge with an
//            APB slave memory and a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_master_bridge;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int TO     = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   last_rsp = 0;

  logic [DATA_W-1:0] ref_mem [32];
  logic [DATA_W-1:0] slv_mem [32];

  apb_master_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  apb_master_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave storage follows what actually appears on the APB bus.
  always @(posedge clk) begin
    if (bus.psel && bus.penable && bus.pready && bus.pwrite && !bus.pslverr) begin
      for (int b = 0; b < 4; b++)
        if (bus.pstrobe[b]) slv_mem[bus.paddr][8*b +: 8] <= bus.pwdata[8*b +: 8];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One complete command; returns at the negedge of the response cycle.
  task automatic xfer(input logic wr, input logic [4:0] addr, input logic [31:0] wd,
                      input logic [3:0] strb, input logic [2:0] prot, input int waits,
                      input logic err, input bit busy_noise);
    int n, guard, acc_cycles;
    logic [31:0] exp_rd;
    logic [44:0] fields;
    bit exp_to;
    bus.cmd_valid  = 1'b1;
    bus.cmd_write  = wr;
    bus.cmd_addr   = addr;
    bus.cmd_wdata  = wd;
    bus.cmd_strobe = strb;
    bus.cmd_prot   = prot;
    guard = 0;
    while (!bus.cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", bus.cmd_ready, 1'b1);
    n = cyc;
    fields = {wr, addr, wd, strb, prot};

    exp_rd     = wr ? 32'h0 : ref_mem[addr];
    exp_to     = 1'b0;
    acc_cycles = waits + 1;
`ifdef APB_MASTER_TIMEOUT_EN
    if (waits > TO) begin
      exp_to     = 1'b1;
      acc_cycles = TO + 1;
    end
`endif
    if (wr && !err && !exp_to)
      for (int b = 0; b < 4; b++)
        if (strb[b]) ref_mem[addr][8*b +: 8] = wd[8*b +: 8];

    @(negedge clk);
    if (busy_noise) begin
      bus.cmd_write  = $urandom;
      bus.cmd_addr   = $urandom;
      bus.cmd_wdata  = $urandom;
      bus.cmd_strobe = $urandom;
      bus.cmd_prot   = $urandom;
    end else begin
      bus.cmd_valid = 1'b0;
    end
    check("setup_sel_en", {bus.psel, bus.penable}, 2'b10);
    check("setup_fields", {bus.pwrite, bus.paddr, bus.pwdata, bus.pstrobe, bus.pprot}, fields);

    @(negedge clk);
    for (int k = 0; k < acc_cycles; k++) begin
      check("access_sel_en", {bus.psel, bus.penable}, 2'b11);
      check("access_fields", {bus.pwrite, bus.paddr, bus.pwdata, bus.pstrobe, bus.pprot}, fields);
      bus.pready  = (k == waits);
      bus.pslverr = (k == waits) ? err : 1'($urandom);
      bus.prdata  = (k == waits) ? slv_mem[bus.paddr] : $urandom;
      @(negedge clk);
    end
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;
    bus.cmd_valid = 1'b0;

    check("rsp_valid",   bus.rsp_valid, 1'b1);
    check("rsp_latency", cyc - n, 3 + acc_cycles - 1);
    check("rsp_rdata",   bus.rsp_rdata, exp_to ? 32'h0 : exp_rd);
    check("rsp_err",     bus.rsp_err, exp_to ? 1'b1 : err);
    check("rsp_timeout", bus.rsp_timeout, exp_to);
    check("rsp_bus_idle", {bus.psel, bus.penable}, 2'b00);
    check("rsp_ready",   bus.cmd_ready, 1'b1);
    last_rsp = cyc;
  endtask

  initial begin
    int prev;
    logic [31:0] v;
    for (int i = 0; i < 32; i++) begin
      v = $urandom;
      ref_mem[i] = v;
      slv_mem[i] = v;
    end
    bus.cmd_valid = 1'b0;  bus.cmd_write = 1'b0;  bus.cmd_addr = '0;
    bus.cmd_wdata = '0;    bus.cmd_strobe = '0;   bus.cmd_prot = '0;
    bus.pready = 1'b0;     bus.pslverr = 1'b0;    bus.prdata = '0;

    repeat (3) @(negedge clk);
    check("reset_outputs", {bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pprot,
                            bus.pstrobe, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, '0);
    check("reset_data", {bus.pwdata, bus.rsp_rdata}, '0);
    check("reset_ready", bus.cmd_ready, 1'b1);
    reset = 1'b0;
    @(negedge clk);

    xfer(1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 3'd0, 0, 1'b0, 1'b0);
    xfer(1'b0, 5'd5, 32'h0, 4'h0, 3'd0, 0, 1'b0, 1'b0);
    check("dir_read_data", bus.rsp_rdata, 32'hDEADBEEF);
    xfer(1'b0, 5'd9, 32'h0, 4'h0, 3'd5, 4, 1'b1, 1'b1);

    prev = last_rsp;
    xfer(1'b1, 5'd12, 32'h1234_5678, 4'b0101, 3'd2, 0, 1'b0, 1'b0);
    check("b2b_gap", last_rsp - prev, 3);

    // Abort mid-ACCESS with reset.
    bus.cmd_valid = 1'b1;  bus.cmd_write = 1'b1;  bus.cmd_addr = 5'd3;
    bus.cmd_wdata = 32'hA5A5_A5A5;  bus.cmd_strobe = 4'hF;  bus.cmd_prot = 3'd1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_access", {bus.psel, bus.penable}, 2'b11);
    reset = 1'b1;
    @(negedge clk);
    check("abort_bus", {bus.psel, bus.penable}, 2'b00);
    check("abort_ready", bus.cmd_ready, 1'b1);
    check("abort_no_rsp", bus.rsp_valid, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_quiet", {bus.psel, bus.rsp_valid}, 2'b00);

`ifdef APB_MASTER_TIMEOUT_EN
    xfer(1'b0, 5'd7, 32'h0, 4'h0, 3'd0, TO + 5, 1'b0, 1'b0);
    xfer(1'b0, 5'd7, 32'h0, 4'h0, 3'd0, TO, 1'b0, 1'b0);
`else
    xfer(1'b0, 5'd7, 32'h0, 4'h0, 3'd0, 40, 1'b0, 1'b0);
`endif

    for (int t = 0; t < 80; t++) begin
      xfer(1'($urandom), 5'($urandom), $urandom, 4'($urandom), 3'($urandom),
           int'($urandom_range(0, 6)), ($urandom_range(0, 3) == 0), 1'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    for (int a = 0; a < 32; a++) begin
      xfer(1'b0, 5'(a), 32'h0, 4'h0, 3'd0, 0, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
